// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
//   state_t     : controller states (IDLE, RUN, DONE)
//   result_t    : packed {eq, gt, lt} result word
//   EQ / GT / LT: one-hot result encodings so consumers decode flags uniformly
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit order is {eq, gt, lt}
   typedef logic [2:0] result_t;

   localparam result_t EQ = 3'b100;
   localparam result_t GT = 3'b010;
   localparam result_t LT = 3'b001;

endpackage

// File: rtl/bit_cmp_cell.sv
// Single-bit magnitude compare cell (combinational).
//   bit_a, bit_b : one bit of each operand
//   invert       : swap the gt/lt sense (used for the two's-complement sign bit)
//   bit_gt       : A bit ranks above B bit
//   bit_lt       : A bit ranks below B bit
//   bit_eq       : bits are identical
module bit_cmp_cell (
   input  logic bit_a,
   input  logic bit_b,
   input  logic invert,
   output logic bit_gt,
   output logic bit_lt,
   output logic bit_eq
);

   logic a_hi_b_lo;
   logic a_lo_b_hi;

   always_comb begin
      a_hi_b_lo = bit_a & ~bit_b;
      a_lo_b_hi = ~bit_a & bit_b;
      bit_eq    = ~(bit_a ^ bit_b);
      // A set sign bit marks a negative value, so a 1 on A ranks lower.
      bit_gt    = invert ? a_lo_b_hi : a_hi_b_lo;
      bit_lt    = invert ? a_hi_b_lo : a_lo_b_hi;
   end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with early termination.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : request a compare (accepted only when idle)
//   sgn        : 1 = two's-complement compare, 0 = unsigned (latched on start)
//   a, b       : operands (latched on start)
//   busy       : compare in progress or result being presented
//   done       : one-cycle pulse when a result has just been loaded
//   eq, gt, lt : registered result of the last completed compare
module serial_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sgn_q;
   logic [IDX_W-1:0] idx, idx_nx;
   result_t          res_q, res_nx;
   logic             load_ops;
   logic             load_res;

   logic cur_a, cur_b, cur_inv;
   logic bit_gt, bit_lt, bit_eq;

   always_comb begin
      cur_a   = a_q[idx];
      cur_b   = b_q[idx];
      cur_inv = sgn_q & (idx == MSB_IDX);
   end

   bit_cmp_cell u_cell (
      .bit_a  (cur_a),
      .bit_b  (cur_b),
      .invert (cur_inv),
      .bit_gt (bit_gt),
      .bit_lt (bit_lt),
      .bit_eq (bit_eq)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         idx   <= '0;
         res_q <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (load_ops) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= sgn;
         end
         if (load_res) begin
            res_q <= res_nx;
         end
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      res_nx   = res_q;
      load_ops = 1'b0;
      load_res = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load_ops = 1'b1;
               idx_nx   = MSB_IDX;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (!bit_eq) begin
               load_res = 1'b1;
               res_nx   = bit_gt ? GT : LT;
               state_nx = DONE;
            end else if (idx == '0) begin
               load_res = 1'b1;
               res_nx   = EQ;
               state_nx = DONE;
            end else begin
               idx_nx = idx - 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
      eq   = res_q[2];
      gt   = res_q[1];
      lt   = res_q[0];
   end

endmodule
